// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM states and shared constants for alu_mc
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'd0;
    localparam logic [OP_W-1:0] OP_SUB  = 4'd1;
    localparam logic [OP_W-1:0] OP_AND  = 4'd2;
    localparam logic [OP_W-1:0] OP_OR   = 4'd3;
    localparam logic [OP_W-1:0] OP_XOR  = 4'd4;
    localparam logic [OP_W-1:0] OP_SLT  = 4'd5;
    localparam logic [OP_W-1:0] OP_SLL  = 4'd6;
    localparam logic [OP_W-1:0] OP_SRL  = 4'd7;
    localparam logic [OP_W-1:0] OP_SRA  = 4'd8;
    localparam logic [OP_W-1:0] OP_SLTU = 4'd9;
    localparam logic [OP_W-1:0] OP_MUL  = 4'd10;

    typedef enum logic {
        IDLE = 1'b0,
        MUL  = 1'b1
    } state_t;

endpackage

// File: rtl/alu_mc_comb.sv
// rtl/alu_mc_comb.sv - combinational single-cycle datapath of alu_mc
module alu_mc_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam int SH = $clog2(WIDTH);

    logic [SH-1:0]    shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;

    assign shamt = b[SH-1:0];
    assign sum   = a + b;
    assign diff  = a - b;

    // mul and the unused opcodes fall through to result 0 / ovf 0
    always_comb begin
        result = '0;
        ovf    = 1'b0;
        case (op)
            OP_ADD: begin
                result = sum;
                ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                result = diff;
                ovf    = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLL:  result = a << shamt;
            OP_SRL:  result = a >> shamt;
            OP_SRA:  result = $signed(a) >>> shamt;
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, (a < b)};
            default: begin
                result = '0;
                ovf    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - handshaked multi-cycle ALU: FSM, shift-add multiplier, output register
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ovf,
    output logic [TAG_W-1:0] out_tag
);

    localparam int SH = $clog2(WIDTH);
    localparam logic [SH-1:0] CNT_LAST = SH'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] acc_d;
    logic [SH-1:0]    cnt_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_result_q;
    logic             out_zero_q;
    logic             out_ovf_q;
    logic [TAG_W-1:0] out_tag_q;

    logic             accept;
    logic [WIDTH-1:0] comb_result;
    logic             comb_ovf;

    alu_mc_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a      (in_a),
        .b      (in_b),
        .op     (in_op),
        .result (comb_result),
        .ovf    (comb_ovf)
    );

    assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // one shift-add step; the last step's sum is what gets registered as the result
    assign acc_d = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            mcand_q      <= '0;
            mplier_q     <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_zero_q   <= 1'b0;
            out_ovf_q    <= 1'b0;
            out_tag_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        out_tag_q <= in_tag;
                        if (in_op == OP_MUL) begin
                            state_q     <= MUL;
                            mcand_q     <= in_a;
                            mplier_q    <= in_b;
                            acc_q       <= '0;
                            cnt_q       <= '0;
                            out_valid_q <= 1'b0;
                        end else begin
                            out_result_q <= comb_result;
                            out_zero_q   <= (comb_result == '0);
                            out_ovf_q    <= comb_ovf;
                            out_valid_q  <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        out_result_q <= acc_d;
                        out_zero_q   <= (acc_d == '0);
                        out_ovf_q    <= 1'b0;
                        out_valid_q  <= 1'b1;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_zero   = out_zero_q;
    assign out_ovf    = out_ovf_q;
    assign out_tag    = out_tag_q;

endmodule
